// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/peripheral data RAM arbiter with starvation guard; DMEM_ARB_STATS_EN adds conflict/stall counters
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_wen,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(STARVE_LIMIT);

  logic [WC_W-1:0] r_wait_cnt;
  logic            r_rd_owner;
  logic            w_starved;
  logic            w_per_gnt;

  // With no starvation budget the peripheral always wins; otherwise it wins once it has lost STARVE_LIMIT times.
  generate
    if (STARVE_LIMIT == 0) begin : g_no_guard
      assign w_starved = 1'b1;
    end else begin : g_guard
      assign w_starved = (r_wait_cnt >= WC_MAX);
    end
  endgenerate

  // Reset gates every grant-derived output so nothing reaches the RAM while CPU_RESETN is low.
  assign w_per_gnt  = CPU_RESETN && per_req && (!cpu_req || w_starved);
  assign per_gnt    = w_per_gnt;
  assign cpu_stall  = cpu_req && w_per_gnt;
  assign cpu_rdata  = ram_rdata;
  assign per_rvalid = r_rd_owner;
  assign per_rdata  = r_rd_owner ? ram_rdata : '0;

  // RAM port mux: the granted peripheral overrides the CPU's default drive.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_wen   = CPU_RESETN && cpu_req && cpu_wen;
    if (w_per_gnt) begin
      ram_addr  = per_addr;
      ram_wdata = per_wdata;
      ram_wen   = per_wen;
    end
  end

  // Count consecutive losses of a pending peripheral request; stops at the limit because the next conflict is a grant.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_wait_cnt <= '0;
    end else if (!per_req || w_per_gnt) begin
      r_wait_cnt <= '0;
    end else if (!w_starved) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Remember that the RAM's next-cycle read data belongs to the peripheral.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_owner <= w_per_gnt && !per_wen;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where both masters requested the RAM.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_conflict_cnt <= '0;
    end else if (cpu_req && per_req && !(&r_conflict_cnt)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  // Saturating count of cycles the CPU was held off the RAM.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_stall_cnt <= '0;
    end else if (cpu_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign stall_cnt    = r_stall_cnt;
`else
  assign conflict_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 16;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              CLK;
  logic              CPU_RESETN;
  logic              cpu_req, cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              per_req, per_wen;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_gnt, per_rvalid;
  logic [DATA_W-1:0] per_rdata;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [CNT_W-1:0]  conflict_cnt, stall_cnt;
  logic              tb_clr;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .per_req(per_req), .per_wen(per_wen), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single-port RAM with 1-cycle synchronous read
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge CLK) begin
    if (tb_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (ram_wen) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state: what the RAM should contain and what the arbiter should have seen
  logic [DATA_W-1:0] shadow [0:4095];
  int                m_losses;
  bit                m_pend;
  logic [DATA_W-1:0] m_pend_data;
  int                m_conf, m_stall;
  bit                m_last_gnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_losses = 0; m_pend = 0; m_pend_data = '0;
    m_conf = 0; m_stall = 0; m_last_gnt = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Compare current DUT outputs to the model, then advance the model across the coming clock edge
  task automatic model_cycle(input string tag);
    bit                e_gnt, e_stall, e_wen;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    if (!CPU_RESETN) begin
      chk({tag, ".gnt"},    32'(per_gnt), 0);
      chk({tag, ".stall"},  32'(cpu_stall), 0);
      chk({tag, ".wen"},    32'(ram_wen), 0);
      chk({tag, ".rvalid"}, 32'(per_rvalid), 0);
      chk({tag, ".conf"},   32'(conflict_cnt), 0);
      chk({tag, ".scnt"},   32'(stall_cnt), 0);
      model_reset();
      return;
    end
    e_gnt   = per_req && (!cpu_req || m_losses >= STARVE_LIMIT);
    e_stall = cpu_req && e_gnt;
    if (e_gnt) begin
      e_addr = per_addr; e_wdata = per_wdata; e_wen = per_wen;
    end else begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_wen = cpu_req && cpu_wen;
    end
    chk({tag, ".gnt"},    32'(per_gnt), 32'(e_gnt));
    chk({tag, ".stall"},  32'(cpu_stall), 32'(e_stall));
    chk({tag, ".wen"},    32'(ram_wen), 32'(e_wen));
    chk({tag, ".addr"},   32'(ram_addr), 32'(e_addr));
    if (e_wen) chk({tag, ".wdata"}, ram_wdata, e_wdata);
    chk({tag, ".rvalid"}, 32'(per_rvalid), 32'(m_pend));
    chk({tag, ".rdata"},  per_rdata, m_pend ? m_pend_data : 32'h0);
    chk({tag, ".cpu_rd"}, cpu_rdata, ram_rdata);
    chk({tag, ".conf"},   32'(conflict_cnt), STATS ? 32'(m_conf) : 32'h0);
    chk({tag, ".scnt"},   32'(stall_cnt), STATS ? 32'(m_stall) : 32'h0);
    if (per_req && !e_gnt) m_losses++;
    else m_losses = 0;
    m_pend = e_gnt && !per_wen;
    if (m_pend) m_pend_data = shadow[per_addr];
    if (e_wen) shadow[e_addr] = e_wdata;
    if (cpu_req && per_req) m_conf = sat_inc(m_conf);
    if (e_stall) m_stall = sat_inc(m_stall);
    m_last_gnt = e_gnt;
  endtask

  // Apply one cycle of inputs at the falling edge and settle before sampling
  task automatic drive(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                       input bit pr, input bit pw, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd);
    @(negedge CLK);
    cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    per_req = pr; per_wen = pw; per_addr = pa; per_wdata = pd;
    #2;
  endtask

  task automatic do_reset(input int cycles, input bit clr);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      CPU_RESETN = 1'b0; tb_clr = clr;
      cpu_req = 1; cpu_wen = 1; cpu_addr = 12'h3FF; cpu_wdata = 32'hFFFF_FFFF;
      per_req = 1; per_wen = 1; per_addr = 12'h3FE; per_wdata = 32'hEEEE_EEEE;
      #2;
      model_cycle("rst");
    end
    @(negedge CLK);
    CPU_RESETN = 1'b1; tb_clr = 1'b0;
    cpu_req = 0; cpu_wen = 0; per_req = 0; per_wen = 0;
    #2;
    model_cycle("rel");
  endtask

  typedef struct {
    bit                cr, cw;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    bit                pr, pw;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    bit                g, st, w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    bit                rv;
    logic [DATA_W-1:0] rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    CPU_RESETN = 1'b0; tb_clr = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    per_req = 0; per_wen = 0; per_addr = '0; per_wdata = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = '0;
    model_reset();

    //          cr cw ca      cd            pr pw pa      pd            g  st w  a       wd            rv rd
    vt[0] = '{1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,        0, 0, 1, 12'h010, 32'hDEADBEEF, 0, 32'h0};
    vt[1] = '{0, 0, 12'h000, 32'h0,        1, 1, 12'h020, 32'h12345678, 1, 0, 1, 12'h020, 32'h12345678, 0, 32'h0};
    vt[2] = '{0, 0, 12'h000, 32'h0,        1, 0, 12'h020, 32'h0,        1, 0, 0, 12'h020, 32'h0,        0, 32'h0};
    vt[3] = '{0, 0, 12'h055, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h055, 32'h0,        1, 32'h12345678};
    vt[4] = '{1, 0, 12'h030, 32'h0,        1, 1, 12'h040, 32'hAAAA5555, 0, 0, 0, 12'h030, 32'h0,        0, 32'h0};
    vt[5] = '{1, 1, 12'h031, 32'h0BADF00D, 0, 0, 12'h000, 32'h0,        0, 0, 1, 12'h031, 32'h0BADF00D, 0, 32'h0};
    vt[6] = '{1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h010, 32'h0,        0, 32'h0};
    vt[7] = '{0, 0, 12'h000, 32'h0,        1, 0, 12'h010, 32'h0,        1, 0, 0, 12'h010, 32'h0,        0, 32'h0};
    vt[8] = '{0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h000, 32'h0,        1, 32'hDEADBEEF};

    do_reset(3, 1'b1);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd);
      chk($sformatf("vec%0d.gnt", i),    32'(per_gnt), 32'(vt[i].g));
      chk($sformatf("vec%0d.stall", i),  32'(cpu_stall), 32'(vt[i].st));
      chk($sformatf("vec%0d.wen", i),    32'(ram_wen), 32'(vt[i].w));
      chk($sformatf("vec%0d.addr", i),   32'(ram_addr), 32'(vt[i].a));
      if (vt[i].w) chk($sformatf("vec%0d.wdata", i), ram_wdata, vt[i].wd);
      chk($sformatf("vec%0d.rvalid", i), 32'(per_rvalid), 32'(vt[i].rv));
      chk($sformatf("vec%0d.rdata", i),  per_rdata, vt[i].rd);
      model_cycle($sformatf("vec%0d", i));
    end

    // Starvation: both masters held for 10 cycles, peripheral must win cycles 5 and 10 only
    do_reset(1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      drive(1, 0, 12'h011, 32'h0, 1, 0, 12'h020, 32'h0);
      chk($sformatf("starve%0d.gnt", c),   32'(per_gnt), 32'((c == 5) || (c == 10)));
      chk($sformatf("starve%0d.stall", c), 32'(cpu_stall), 32'((c == 5) || (c == 10)));
      if (c == 6) chk("starve6.rdata", per_rdata, 32'h12345678);
      model_cycle($sformatf("starve%0d", c));
    end
    drive(0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 32'h0);
    chk("starve.rvalid", 32'(per_rvalid), 1);
    chk("starve.rdata", per_rdata, 32'h12345678);
    chk("stats.conflict", 32'(conflict_cnt), STATS ? 32'd10 : 32'd0);
    chk("stats.stall", 32'(stall_cnt), STATS ? 32'd2 : 32'd0);
    model_cycle("starve_end");

    // Reset clears an accumulated wait count
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 12'h011, 32'h0, 1, 0, 12'h010, 32'h0);
      model_cycle("wpre");
    end
    do_reset(1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      drive(1, 0, 12'h011, 32'h0, 1, 0, 12'h010, 32'h0);
      chk($sformatf("wpost%0d.gnt", c), 32'(per_gnt), 32'(c == 5));
      model_cycle($sformatf("wpost%0d", c));
    end

    // Reset lands between a peripheral read grant and its data return
    drive(0, 0, 12'h000, 32'h0, 1, 0, 12'h020, 32'h0);
    chk("midrd.gnt", 32'(per_gnt), 1);
    model_cycle("midrd");
    #1;
    CPU_RESETN = 1'b0;
    model_reset();
    #1;
    chk("midrd.gnt_rst", 32'(per_gnt), 0);
    chk("midrd.rvalid_rst", 32'(per_rvalid), 0);
    do_reset(1, 1'b0);
    chk("midrd.rvalid_rel", 32'(per_rvalid), 0);
    drive(0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 32'h0);
    chk("midrd.rvalid_after", 32'(per_rvalid), 0);
    model_cycle("midrd_after");

    // Randomized traffic; the peripheral holds its request until granted
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      cpu_req   = ($urandom_range(0, 99) < 70);
      cpu_wen   = $urandom_range(0, 1) == 1;
      cpu_addr  = 12'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      if (!(per_req && !m_last_gnt)) begin
        per_req   = ($urandom_range(0, 99) < 60);
        per_wen   = $urandom_range(0, 1) == 1;
        per_addr  = 12'($urandom_range(0, 63));
        per_wdata = $urandom;
      end
      #2;
      model_cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
